// File: rtl/ulpi_reg_arb.sv
// ULPI register-access arbiter: grants the PHY bus round-robin to two requesters,
// sequences REGW/REGR TX CMDs, yields to PHY traffic and times out stalled waits.
module ulpi_reg_arb #(
  parameter int TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dir,
  input  logic       i_nxt,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_stp,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_we0,
  input  logic       i_we1,
  input  logic [5:0] i_addr0,
  input  logic [5:0] i_addr1,
  input  logic [7:0] i_wdata0,
  input  logic [7:0] i_wdata1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_err,
  output logic [7:0] o_rdata,
  output logic       o_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WDATA, S_STP, S_RD_TURN, S_RD_DATA, S_RD_END
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] req_q, req_d, mask_q, mask_d, ack_q, ack_d;
  logic       last_q, last_d, gnt_q, gnt_d, we_q, we_d, stp_q, stp_d, err_q, err_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, data_q, data_d, rdata_q, rdata_d;

  logic [1:0] pend;
  logic       sel, timed_out, counting;

  // A port that was just acked stays masked until its requester drops i_req.
  assign pend      = req_q & ~mask_q;
  assign sel       = (pend == 2'b11) ? ~last_q : pend[1];
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
  assign counting  = (state_q == S_CMD) || (state_q == S_WDATA) ||
                     (state_q == S_RD_TURN) || (state_q == S_RD_END);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 2'b00;
      mask_q  <= 2'b00;
      ack_q   <= 2'b00;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      stp_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      stp_q   <= stp_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; abort (i_dir) has priority over i_nxt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!i_dir && (pend != 2'b00)) state_d = S_CMD;
      S_CMD: begin
        if (i_dir)          state_d = S_IDLE;
        else if (i_nxt)     state_d = we_q ? S_WDATA : S_RD_TURN;
        else if (timed_out) state_d = S_IDLE;
      end
      S_WDATA: begin
        if (i_dir)          state_d = S_IDLE;
        else if (i_nxt)     state_d = S_STP;
        else if (timed_out) state_d = S_IDLE;
      end
      S_STP:     state_d = S_IDLE;
      S_RD_TURN: begin
        if (i_dir)          state_d = S_RD_DATA;
        else if (timed_out) state_d = S_IDLE;
      end
      S_RD_DATA: state_d = S_RD_END;
      S_RD_END:  if (!i_dir || timed_out) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : (counting ? cnt_q + CW'(1) : cnt_q);
  end

  always_comb begin
    data_d  = 8'h00;
    stp_d   = 1'b0;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = {i_req1, i_req0};
    case (state_q)
      S_IDLE: begin
        if (!i_dir && (pend != 2'b00)) begin
          gnt_d   = sel;
          we_d    = sel ? i_we1 : i_we0;
          addr_d  = sel ? i_addr1 : i_addr0;
          wdata_d = sel ? i_wdata1 : i_wdata0;
          data_d  = {(sel ? i_we1 : i_we0) ? 2'b10 : 2'b11, sel ? i_addr1 : i_addr0};
        end
      end
      S_CMD: begin
        // On abort, point the tie-break at the aborted port so it is retried first.
        if (i_dir) last_d = ~gnt_q;
        else if (i_nxt) data_d = we_q ? wdata_q : 8'h00;
        else if (timed_out) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = 1'b1;
          last_d       = gnt_q;
        end else data_d = {we_q ? 2'b10 : 2'b11, addr_q};
      end
      S_WDATA: begin
        if (i_dir) last_d = ~gnt_q;
        else if (i_nxt) stp_d = 1'b1;
        else if (timed_out) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = 1'b1;
          last_d       = gnt_q;
        end else data_d = wdata_q;
      end
      S_STP: begin
        ack_d[gnt_q] = 1'b1;
        last_d       = gnt_q;
      end
      S_RD_TURN: begin
        if (!i_dir && timed_out) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = 1'b1;
          last_d       = gnt_q;
        end
      end
      S_RD_DATA: rdata_d = i_data;
      S_RD_END: begin
        if (!i_dir || timed_out) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = i_dir;
          last_d       = gnt_q;
        end
      end
      default: ;
    endcase
    mask_d = (mask_q | ack_d) & {i_req1, i_req0};
  end

  assign o_data  = data_q;
  assign o_stp   = stp_q;
  assign o_ack0  = ack_q[0];
  assign o_ack1  = ack_q[1];
  assign o_err   = err_q;
  assign o_rdata = rdata_q;
  assign o_busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_ulpi_reg_arb.sv
// Directed bench for ulpi_reg_arb: write, read, round-robin, PHY abort, timeout, async reset.
module tb_ulpi_reg_arb;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir = 1'b0, nxt = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] o_data, o_rdata;
  logic       o_stp, o_ack0, o_ack1, o_err, o_busy;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [5:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;

  int checks = 0;
  int errors = 0;

  ulpi_reg_arb dut (
    .i_clk(clk), .i_rst(rst), .i_dir(dir), .i_nxt(nxt), .i_data(din),
    .o_data(o_data), .o_stp(o_stp),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(o_ack0), .o_ack1(o_ack1), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  initial begin
    int n;
    int n0, n1;
    logic pa0, pa1;
    logic [7:0] g;

    // Reset values
    #2;
    chk8("rst_data", o_data, 8'h00);
    chk1("rst_stp", o_stp, 1'b0);
    chk1("rst_ack0", o_ack0, 1'b0);
    chk1("rst_ack1", o_ack1, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    chk8("rst_rdata", o_rdata, 8'h00);
    chk1("rst_busy", o_busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Port 0 write 0x04 <= 0x45, nxt immediate
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h04; wdata0 = 8'h45; nxt = 1'b1;
    tick();
    chk8("w_e0_data", o_data, 8'h00);
    chk1("w_e0_busy", o_busy, 1'b0);
    tick();
    chk8("w_cmd", o_data, 8'h84);
    chk1("w_busy", o_busy, 1'b1);
    tick();
    chk8("w_wdata", o_data, 8'h45);
    chk1("w_stp_lo", o_stp, 1'b0);
    tick();
    chk8("w_stp_data", o_data, 8'h00);
    chk1("w_stp_hi", o_stp, 1'b1);
    chk1("w_noack", o_ack0, 1'b0);
    tick();
    chk1("w_stp_end", o_stp, 1'b0);
    chk1("w_ack0", o_ack0, 1'b1);
    chk1("w_ack1", o_ack1, 1'b0);
    chk1("w_err", o_err, 1'b0);
    req0 = 1'b0;
    tick();
    chk1("w_ack0_single", o_ack0, 1'b0);
    chk1("w_idle", o_busy, 1'b0);

    // Port 1 read 0x0A, PHY returns 0x5A
    nxt = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 6'h0A;
    tick();
    tick();
    chk8("r_cmd", o_data, 8'hCA);
    tick();
    chk8("r_cmd_hold", o_data, 8'hCA);
    nxt = 1'b1;
    tick();
    chk8("r_turn_data", o_data, 8'h00);
    nxt = 1'b0; dir = 1'b1;
    tick();
    chk1("r_data_busy", o_busy, 1'b1);
    din = 8'h5A;
    tick();
    chk8("r_rdata", o_rdata, 8'h5A);
    chk1("r_noack", o_ack1, 1'b0);
    dir = 1'b0; din = 8'h00;
    tick();
    chk1("r_ack1", o_ack1, 1'b1);
    chk1("r_ack0", o_ack0, 1'b0);
    chk1("r_err", o_err, 1'b0);
    chk8("r_rdata_ack", o_rdata, 8'h5A);
    req1 = 1'b0;
    tick();
    chk1("r_ack1_single", o_ack1, 1'b0);
    tick();

    // Both ports write continuously; grants must alternate 0,1,0,1
    nxt = 1'b1;
    we0 = 1'b1; addr0 = 6'h01; wdata0 = 8'h11;
    we1 = 1'b1; addr1 = 6'h02; wdata1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    exp_q = '{8'd0, 8'd1, 8'd0, 8'd1};
    n0 = 0; n1 = 0; pa0 = 1'b0; pa1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pa0) chk1("rr_ack0_single", o_ack0, 1'b0);
      if (pa1) chk1("rr_ack1_single", o_ack1, 1'b0);
      pa0 = o_ack0; pa1 = o_ack1;
      if (o_ack0) begin got_q.push_back(8'd0); n0++; req0 = 1'b0; end
      else if (!req0 && n0 < 2) req0 = 1'b1;
      if (o_ack1) begin got_q.push_back(8'd1); n1++; req1 = 1'b0; end
      else if (!req1 && n1 < 2) req1 = 1'b1;
    end
    chk32("rr_count", got_q.size(), 4);
    foreach (exp_q[k]) begin
      g = (k < got_q.size()) ? got_q[k] : 8'hFF;
      chk8("rr_order", g, exp_q[k]);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk1("rr_idle", o_busy, 1'b0);

    // PHY dir during CMD of a port 1 write: abort, then port 1 retried before port 0
    nxt = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h07; wdata1 = 8'h77;
    tick();
    tick();
    chk8("ab_cmd", o_data, 8'h87);
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h03; wdata0 = 8'h33;
    dir = 1'b1; nxt = 1'b1;
    tick();
    chk8("ab_data0", o_data, 8'h00);
    chk1("ab_idle", o_busy, 1'b0);
    chk1("ab_noack", o_ack1, 1'b0);
    tick();
    chk8("ab_hold0", o_data, 8'h00);
    dir = 1'b0;
    tick();
    chk8("ab_regrant1", o_data, 8'h87);
    tick();
    chk8("ab_wdata1", o_data, 8'h77);
    tick();
    chk1("ab_stp", o_stp, 1'b1);
    tick();
    chk1("ab_ack1", o_ack1, 1'b1);
    chk1("ab_ack0_lo", o_ack0, 1'b0);
    req1 = 1'b0;
    tick();
    chk8("ab_grant0", o_data, 8'h83);
    tick();
    tick();
    tick();
    chk1("ab_ack0", o_ack0, 1'b1);
    chk1("ab_err0", o_err, 1'b0);
    req0 = 1'b0;
    tick();

    // PHY never asserts nxt: error ack after TIMEOUT cycles in CMD
    nxt = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h05; wdata0 = 8'h55;
    tick();
    tick();
    chk8("to_cmd", o_data, 8'h85);
    n = 0;
    while (!o_ack0 && n < TIMEOUT + 8) begin
      tick();
      n++;
    end
    chk32("to_cycles", n, TIMEOUT);
    chk1("to_ack0", o_ack0, 1'b1);
    chk1("to_err", o_err, 1'b1);
    chk1("to_stp", o_stp, 1'b0);
    chk8("to_data", o_data, 8'h00);
    chk1("to_idle", o_busy, 1'b0);
    req0 = 1'b0;
    tick();
    chk1("to_err_clr", o_err, 1'b0);

    // Async reset during WDATA, then a fresh write completes
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h06; wdata0 = 8'h66;
    tick();
    tick();
    chk8("rs_cmd", o_data, 8'h86);
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    tick();
    chk8("rs_wdata", o_data, 8'h66);
    chk1("rs_busy", o_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk8("rs_data0", o_data, 8'h00);
    chk1("rs_stp0", o_stp, 1'b0);
    chk1("rs_busy0", o_busy, 1'b0);
    chk1("rs_ack0", o_ack0, 1'b0);
    req0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk1("rs_noack", o_ack0, 1'b0);
    nxt = 1'b1; req0 = 1'b1;
    tick();
    tick();
    chk8("rs2_cmd", o_data, 8'h86);
    tick();
    chk8("rs2_wdata", o_data, 8'h66);
    tick();
    chk1("rs2_stp", o_stp, 1'b1);
    tick();
    chk1("rs2_ack0", o_ack0, 1'b1);
    chk1("rs2_err", o_err, 1'b0);
    req0 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ulpi_reg_arb.md
# ulpi_reg_arb

Arbitrating sequencer for ULPI PHY register access. It sits between the ULPI link controller's idle phase and two internal register-access requesters (port 0: link init/config sequencer; port 1: debug/host CSR path). It grants the ULPI bus to one requester at a time, issues the ULPI REGW/REGR TX CMD sequence on `o_data`/`o_stp`, and returns read data with a per-port acknowledge. It yields to PHY-initiated traffic (`i_dir` high) and retries aborted transfers.

## Interface
- `TIMEOUT` (default 64): max cycles waited for `i_nxt`/`i_dir` in any wait state before error completion.
- `i_clk`  in  1  ULPI 60 MHz clock; all logic on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_dir`  in  1  ULPI dir from PHY.
- `i_nxt`  in  1  ULPI nxt from PHY.
- `i_data`  in  8  ULPI data from PHY.
- `o_data`  out  8  ULPI data to PHY (registered).
- `o_stp`  out  1  ULPI stp (registered).
- `i_req0`, `i_req1`  in  1  access request; held high until matching ack.
- `i_we0`, `i_we1`  in  1  1 = register write, 0 = read.
- `i_addr0`, `i_addr1`  in  6  PHY register address.
- `i_wdata0`, `i_wdata1`  in  8  write data.
- `o_ack0`, `o_ack1`  out  1  one-cycle completion pulse.
- `o_err`  out  1  valid with ack; 1 = timeout.
- `o_rdata`  out  8  read data; valid with ack on reads, held until next read.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CMD, WDATA, STP, RD_TURN, RD_DATA, RD_END.
- IDLE: if `i_dir`=0 and any request is pending, grant round-robin. The port not granted last wins a tie. After reset, port 0 wins.
  - Latch we/addr/wdata of the granted port.
  - Drive `o_data` <= {we ? 2'b10 : 2'b11, addr}; go to CMD.
  - If `i_dir`=1, stay in IDLE with `o_data`=0.
- CMD:
  - `i_dir`=1: abort. `o_data`<=0, go to IDLE, keep the grant pointer (the same port is retried first).
  - `i_nxt`=1, write: `o_data`<=wdata, go to WDATA.
  - `i_nxt`=1, read: `o_data`<=0, go to RD_TURN.
- WDATA:
  - `i_dir`=1: abort as in CMD.
  - `i_nxt`=1: `o_stp`<=1, `o_data`<=0, go to STP.
- STP: `o_stp`<=0, pulse ack (err=0), rotate the grant pointer, go to IDLE.
- RD_TURN: on `i_dir`=1 (turnaround cycle) go to RD_DATA.
- RD_DATA: `o_rdata`<=`i_data`, go to RD_END.
- RD_END: on `i_dir`=0, pulse ack (err=0), rotate the pointer, go to IDLE.
- Timeout: a counter clears on every state change and increments in CMD, WDATA, RD_TURN and RD_END.
  - At `TIMEOUT`: `o_data`<=0, `o_stp`<=0, pulse ack with `o_err`=1, rotate the pointer, go to IDLE.
  - An abort is not a timeout and does not consume the request.
- A requester deasserting `i_req` mid-transaction is ignored; the transaction completes and acks.
- `o_data` is always 0 in any cycle where the registered state is IDLE/RD_* or after `i_dir` is seen high.

## Timing
- Reset values: `o_data`=0, `o_stp`=0, `o_ack0`=`o_ack1`=0, `o_err`=0, `o_rdata`=0, `o_busy`=0, state IDLE, grant pointer favours port 0.
- Reset asserted mid-transaction: outputs return to reset values immediately; no ack is issued.
- Write with `i_nxt` given on first CMD and first WDATA cycles:
  - request sampled at edge 0;
  - CMD on `o_data` from edge 1; data from edge 2;
  - `o_stp` high for edge 3 → 4;
  - ack at edge 4 → 5;
  - total 5 cycles request-to-ack.
- Read with PHY nxt at CMD cycle 1, dir high the next cycle, data the cycle after, dir low the cycle after that:
  - ack 6 cycles after request sample.
- Ack is a single cycle.
- The next grant can occur on the cycle after ack (IDLE with `i_req` still high is not re-sampled for the acked port until it drops, so requesters must drop `i_req` on ack).
- Simultaneous `i_dir` rise and `i_nxt` in CMD/WDATA: abort wins.

## Test plan
- Port 0 write, addr 0x04, data 0x45, PHY nxt immediately → `o_data` sequence 0x84, 0x45, 0x00 with `o_stp` pulsed 1 cycle, `o_ack0` 5 cycles after req, `o_err`=0.
- Port 1 read, addr 0x0A, PHY returns 0x5A → `o_data`=0xCA until nxt, `o_rdata`=0x5A with `o_ack1`, `o_err`=0.
- Both ports request continuously with alternating writes → grants alternate 0,1,0,1; no port is starved; each ack is exactly one cycle.
- PHY raises `i_dir` during CMD of a port 1 write → `o_data`=0 the next cycle, IDLE; after dir falls, port 1 is re-granted before port 0 and completes normally.
- PHY never asserts `i_nxt` → ack with `o_err`=1 after `TIMEOUT` cycles in CMD; `o_stp`=0; bus returns to idle.
- `i_rst` pulsed during WDATA → `o_stp`/`o_data` 0 and `o_busy` 0 asynchronously; no ack; a fresh request afterwards completes.
